// File: rtl/bp_update_queue.sv
// In-order queue of predicted conditional branches between fetch and execute.
// When the oldest branch resolves, it emits a registered one-cycle update bundle for the tournament chooser.
module bp_update_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic                     push_gshare,
  input  logic                     push_local,
  input  logic                     push_choice,
  input  logic [IDX_W-1:0]         push_index,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     update,
  output logic                     taken,
  output logic                     Gshare,
  output logic                     Local,
  output logic [IDX_W-1:0]         GPT_index_update,
  output logic [31:0]              pc_ex,
  output logic                     mispredict,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]      pcMem     [DEPTH];
  logic [IDX_W-1:0] idxMem    [DEPTH];
  logic             gshareMem [DEPTH];
  logic             localMem  [DEPTH];
  logic             choiceMem [DEPTH];

  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             update_q, taken_q, gshare_q, local_q, mispredict_q, err_q, err_d;
  logic [IDX_W-1:0] index_q;
  logic [31:0]      pc_q;

  logic isFull, isEmpty, popEff, pushEff, selPred;

  assign isFull  = (count_q == FULL_CNT);
  assign isEmpty = (count_q == '0);
  assign popEff  = resolve && !isEmpty;
  // A full queue still accepts a push when the oldest entry leaves in the same cycle.
  assign pushEff = push && !flush && (!isFull || popEff);
  assign selPred = choiceMem[rp_q] ? gshareMem[rp_q] : localMem[rp_q];

  always_comb begin
    wp_d    = wp_q + PW'(pushEff);
    rp_d    = rp_q + PW'(popEff);
    count_d = count_q + CW'(pushEff) - CW'(popEff);
    // Flush lands after the pop; the dropped push never moved wp, so rp simply catches up.
    if (flush) begin
      rp_d    = wp_q;
      count_d = '0;
    end
    err_d = err_q || (resolve && isEmpty) || (push && isFull && !popEff && !flush);
  end

  always_ff @(posedge clk) begin
    if (pushEff) begin
      pcMem[wp_q]     <= push_pc;
      idxMem[wp_q]    <= push_index;
      gshareMem[wp_q] <= push_gshare;
      localMem[wp_q]  <= push_local;
      choiceMem[wp_q] <= push_choice;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      update_q     <= 1'b0;
      taken_q      <= 1'b0;
      gshare_q     <= 1'b0;
      local_q      <= 1'b0;
      mispredict_q <= 1'b0;
      index_q      <= '0;
      pc_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      err_q        <= err_d;
      update_q     <= popEff;
      mispredict_q <= popEff && (selPred ^ resolve_taken);
      if (popEff) begin
        taken_q  <= resolve_taken;
        gshare_q <= gshareMem[rp_q];
        local_q  <= localMem[rp_q];
        index_q  <= idxMem[rp_q];
        pc_q     <= pcMem[rp_q];
      end
    end
  end

  assign full             = isFull;
  assign empty            = isEmpty;
  assign count            = count_q;
  assign update           = update_q;
  assign taken            = taken_q;
  assign Gshare           = gshare_q;
  assign Local            = local_q;
  assign GPT_index_update = index_q;
  assign pc_ex            = pc_q;
  assign mispredict       = mispredict_q;
  assign err              = err_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: ordering, full/empty handling, flush, pointer wrap and async reset.
module tb_bp_update_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             push, push_gshare, push_local, push_choice;
  logic [31:0]      push_pc;
  logic [IDX_W-1:0] push_index;
  logic             resolve, resolve_taken, flush;
  logic             full, empty, update, taken, Gshare, Local, mispredict, err;
  logic [2:0]       count;
  logic [IDX_W-1:0] GPT_index_update;
  logic [31:0]      pc_ex;

  int checks = 0;
  int failures = 0;

  bp_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .push(push), .push_pc(push_pc), .push_gshare(push_gshare), .push_local(push_local),
    .push_choice(push_choice), .push_index(push_index),
    .resolve(resolve), .resolve_taken(resolve_taken), .flush(flush),
    .full(full), .empty(empty), .count(count), .update(update), .taken(taken),
    .Gshare(Gshare), .Local(Local), .GPT_index_update(GPT_index_update), .pc_ex(pc_ex),
    .mispredict(mispredict), .err(err)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here so the counters stay consistent.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, lets the rising edge take them, then idles the inputs 1ns later.
  task automatic applyStimulus(input logic p, input logic [31:0] pc, input logic [IDX_W-1:0] idx,
                               input logic g, input logic l, input logic c,
                               input logic r, input logic t, input logic f);
    push = p; push_pc = pc; push_index = idx; push_gshare = g; push_local = l; push_choice = c;
    resolve = r; resolve_taken = t; flush = f;
    @(posedge clk);
    #1;
    push = 0; resolve = 0; resolve_taken = 0; flush = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic g, l, c, t;
    int j;
    push = 0; push_pc = 0; push_index = 0; push_gshare = 0; push_local = 0; push_choice = 0;
    resolve = 0; resolve_taken = 0; flush = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_update", update, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_idx", GPT_index_update, 0);
    checkOutput("rst_pc", pc_ex, 0);
    checkOutput("rst_misp", mispredict, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] basic push and resolve");
    applyStimulus(1, 32'h100, 5, 1, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h104, 6, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h108, 7, 1, 1, 1, 0, 0, 0);
    checkOutput("fill3_count", count, 3);
    checkOutput("fill3_update", update, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("r0_update", update, 1);
    checkOutput("r0_idx", GPT_index_update, 5);
    checkOutput("r0_pc", pc_ex, 32'h100);
    checkOutput("r0_misp", mispredict, 0);
    checkOutput("r0_taken", taken, 1);
    checkOutput("r0_gshare", Gshare, 1);
    checkOutput("r0_local", Local, 0);
    checkOutput("r0_count", count, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("r1_update", update, 1);
    checkOutput("r1_idx", GPT_index_update, 6);
    checkOutput("r1_misp", mispredict, 1);
    checkOutput("r1_count", count, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("r2_update", update, 1);
    checkOutput("r2_idx", GPT_index_update, 7);
    checkOutput("r2_pc", pc_ex, 32'h108);
    checkOutput("r2_misp", mispredict, 1);
    checkOutput("r2_taken", taken, 0);
    checkOutput("r2_count", count, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_update", update, 0);
    checkOutput("idle_misp", mispredict, 0);
    checkOutput("idle_idx_hold", GPT_index_update, 7);
    checkOutput("idle_empty", empty, 1);
    checkOutput("idle_err", err, 0);

    $display("[TB] full queue handling");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 32'h200 + 32'(4 * i), IDX_W'(10 + i), 1'(i), 0, 1, 0, 0, 0);
    checkOutput("full_flag", full, 1);
    checkOutput("full_count", count, 4);
    applyStimulus(1, 32'h300, 20, 0, 0, 1, 1, 1, 0);
    checkOutput("fullpr_update", update, 1);
    checkOutput("fullpr_idx", GPT_index_update, 10);
    checkOutput("fullpr_count", count, 4);
    checkOutput("fullpr_err", err, 0);
    applyStimulus(1, 32'h304, 21, 0, 0, 1, 0, 0, 0);
    checkOutput("fulldrop_count", count, 4);
    checkOutput("fulldrop_err", err, 1);
    checkOutput("fulldrop_update", update, 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("drain%0d_idx", i), GPT_index_update, (i < 3) ? 11 + i : 20);
    end
    checkOutput("drain_empty", empty, 1);

    $display("[TB] resolve on empty");
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("emptyres_update", update, 0);
    checkOutput("emptyres_err", err, 1);
    checkOutput("emptyres_count", count, 0);

    $display("[TB] flush with pop and push");
    doReset();
    applyStimulus(1, 32'h400, 30, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 32'h404, 31, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h408, 32, 0, 0, 0, 1, 0, 1);
    checkOutput("flush_update", update, 1);
    checkOutput("flush_idx", GPT_index_update, 30);
    checkOutput("flush_misp", mispredict, 1);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_err", err, 0);
    applyStimulus(1, 32'h500, 40, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("postflush_idx", GPT_index_update, 40);
    checkOutput("postflush_pc", pc_ex, 32'h500);
    checkOutput("postflush_misp", mispredict, 0);
    checkOutput("postflush_err", err, 0);

    $display("[TB] pointer wrap");
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i < 10, 32'h1000 + 32'(8 * i), IDX_W'(50 + i), 1'(i), 1'(i >> 1), 1'(i >> 2),
                    i >= 2, ((i - 2) % 3) == 0, 0);
      checkOutput($sformatf("wrap%0d_count", i), count, (i == 0 || i == 10) ? 1 : (i == 11) ? 0 : 2);
      if (i >= 2) begin
        j = i - 2;
        g = 1'(j); l = 1'(j >> 1); c = 1'(j >> 2); t = (j % 3) == 0;
        checkOutput($sformatf("wrap%0d_idx", j), GPT_index_update, 50 + j);
        checkOutput($sformatf("wrap%0d_pc", j), pc_ex, 32'h1000 + 8 * j);
        checkOutput($sformatf("wrap%0d_misp", j), mispredict, (c ? g : l) ^ t);
        checkOutput($sformatf("wrap%0d_update", j), update, 1);
      end
    end
    checkOutput("wrap_err", err, 0);

    $display("[TB] asynchronous reset mid-operation");
    doReset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 32'h2000 + 32'(4 * i), IDX_W'(60 + i), 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("pre_arst_update", update, 1);
    checkOutput("pre_arst_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_update", update, 0);
    checkOutput("arst_count", count, 0);
    checkOutput("arst_empty", empty, 1);
    checkOutput("arst_idx", GPT_index_update, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1, 32'h3000, 99, 0, 0, 0, 0, 0, 0);
    checkOutput("post_arst_count", count, 1);
    checkOutput("post_arst_empty", empty, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("post_arst_idx", GPT_index_update, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
